// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: access-size encodings
// and the arbiter FSM state type.
// Optional build macro: MEM_ARB_TIMEOUT_EN (undefined by default).
package mem_bus_arbiter_pkg;

    // Access size encodings presented on SIZE / d_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

    // True while an access is outstanding on the bus
    function automatic logic is_busy(input arb_state_e s);
        return (s == ST_BUSY_D) || (s == ST_BUSY_I);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter: counts consecutive data grants taken while a fetch
// is waiting, and raises force_fetch once STARVE_MAX has been reached.
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic gnt_data,
    input  logic gnt_fetch,
    output logic force_fetch
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear when no fetch waits or fetch is granted, else saturate up on data grants
    always_comb begin
        cnt_d = cnt_q;
        if (!i_req || gnt_fetch) begin
            cnt_d = '0;
        end else if (gnt_data && (cnt_q != CNT_W'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single external memory port between the instruction-fetch
// and MEM-stage data requesters. The winning request is registered onto
// the bus, held until mem_rdy, and completed with a one-cycle ack.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds bus_err and a BUSY
// timeout of TIMEOUT_CYC cycles.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              MREQ,
    output logic              WRITE,
    output logic [1:0]        SIZE,
    output logic [ADDR_W-1:0] DAD,
    output logic [DATA_W-1:0] DDT_o,
    output logic              DDT_oe,
    input  logic [DATA_W-1:0] DDT_i,
    input  logic              mem_rdy,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic              bus_err,
`endif
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e        state_q, state_d;
    logic              mreq_q, mreq_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] dad_q, dad_d;
    logic [DATA_W-1:0] ddt_o_q, ddt_o_d;
    logic              ddt_oe_q, ddt_oe_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              gnt_data, gnt_fetch;
    logic              force_fetch;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              timed_out;

    assign timed_out = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .gnt_data    (gnt_data),
        .gnt_fetch   (gnt_fetch),
        .force_fetch (force_fetch)
    );

    // Next-state and bus register logic: arbitrate in IDLE, hold in BUSY, pulse ack in ACK
    always_comb begin
        state_d   = state_q;
        mreq_d    = mreq_q;
        write_d   = write_q;
        size_d    = size_q;
        dad_d     = dad_q;
        ddt_o_d   = ddt_o_q;
        ddt_oe_d  = ddt_oe_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        gnt_data  = 1'b0;
        gnt_fetch = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        bus_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Data has priority unless fetch has waited through STARVE_MAX data grants
                if (i_req && (force_fetch || !d_req)) begin
                    gnt_fetch = 1'b1;
                    mreq_d    = 1'b1;
                    write_d   = 1'b0;
                    size_d    = SIZE_WORD;
                    dad_d     = i_addr;
                    ddt_oe_d  = 1'b0;
                    state_d   = ST_BUSY_I;
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end else if (d_req) begin
                    gnt_data  = 1'b1;
                    mreq_d    = 1'b1;
                    write_d   = d_write;
                    size_d    = d_size;
                    dad_d     = d_addr;
                    ddt_o_d   = d_wdata;
                    ddt_oe_d  = d_write;
                    state_d   = ST_BUSY_D;
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end
            ST_BUSY_D, ST_BUSY_I: begin
                if (mem_rdy) begin
                    if (state_q == ST_BUSY_I) begin
                        i_rdata_d = DDT_i;
                        i_ack_d   = 1'b1;
                    end else begin
                        // Stores leave the last load data untouched
                        if (!write_q) begin
                            d_rdata_d = DDT_i;
                        end
                        d_ack_d = 1'b1;
                    end
                    mreq_d   = 1'b0;
                    write_d  = 1'b0;
                    ddt_oe_d = 1'b0;
                    state_d  = ST_ACK;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (timed_out) begin
                    // Abort: complete the access with an error and no data
                    i_ack_d   = (state_q == ST_BUSY_I);
                    d_ack_d   = (state_q == ST_BUSY_D);
                    bus_err_d = 1'b1;
                    mreq_d    = 1'b0;
                    write_d   = 1'b0;
                    ddt_oe_d  = 1'b0;
                    state_d   = ST_ACK;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mreq_q    <= 1'b0;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            dad_q     <= '0;
            ddt_o_q   <= '0;
            ddt_oe_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mreq_q    <= mreq_d;
            write_q   <= write_d;
            size_q    <= size_d;
            dad_q     <= dad_d;
            ddt_o_q   <= ddt_o_d;
            ddt_oe_q  <= ddt_oe_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout counter and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`endif

    assign MREQ      = mreq_q;
    assign WRITE     = write_q;
    assign SIZE      = size_q;
    assign DAD       = dad_q;
    assign DDT_o     = ddt_o_q;
    assign DDT_oe    = ddt_oe_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign stall_if  = i_req & ~i_ack_q;
    assign stall_mem = d_req & ~d_ack_q;

endmodule
